ofdm_cp_insert: RTL

//  Downstream of the TRANS IFFT output. Takes time-domain OFDM symbols of NFFT samples
//  (do_re/do_im/do_vld style stream) and emits NCP+NFFT samples per symbol, cyclic prefix first.

---
 rtl/ofdm_cp_insert_pkg.sv | 19 +
 rtl/cpi_dpram.sv | 43 ++++
 rtl/ofdm_cp_insert.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_cp_insert_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_cp_insert_pkg
//   Shared definitions for the OFDM cyclic-prefix inserter:
//   default geometry (sample width, FFT size, prefix length) and the
//   read-side state encoding.
// ---------------------------------------------------------------------------
package ofdm_cp_insert_pkg;

   localparam int CPI_DW   = 12;   // sample width per rail
   localparam int CPI_NFFT = 64;   // samples per symbol (power of 2)
   localparam int CPI_NCP  = 16;   // cyclic prefix length

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for a full bank
      ST_CP   = 2'd1,   // replaying the symbol tail as prefix
      ST_BODY = 2'd2    // emitting the whole symbol
   } rd_state_t;

endpackage

// File: rtl/cpi_dpram.sv
// ---------------------------------------------------------------------------
// cpi_dpram
//   Simple dual-port RAM: one synchronous write port, one read port with a
//   registered output (read latency 1).
//   Ports:
//     i_clk    clock
//     i_we     write enable
//     i_waddr  write address
//     i_wdata  write data
//     i_re     read enable (output register loads only when set)
//     i_raddr  read address
//     o_rdata  registered read data
// ---------------------------------------------------------------------------
module cpi_dpram #(
   parameter int AW = 7,
   parameter int WW = 24
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [WW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [WW-1:0] o_rdata
);

   logic [WW-1:0] r_mem [0:(1<<AW)-1];

   // Synchronous write port
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/ofdm_cp_insert.sv
// ---------------------------------------------------------------------------
// ofdm_cp_insert
//   Cyclic-prefix inserter. Collects NFFT-sample symbols into one of two
//   RAM banks (ping-pong) and replays each full bank as NCP prefix samples
//   (tail of the symbol) followed by the NFFT symbol samples, back-to-back.
//   Optional build macro CPI_WIN_EN: the first prefix sample of a symbol
//   that directly follows another symbol is averaged with the previous
//   symbol's last sample (floor of the mean).
//   Ports:
//     pld_clk, pld_rst      clock, asynchronous active-high reset
//     di_re/di_im/di_vld    input sample stream, di_sos marks sample 0
//     di_rdy                a write bank is free
//     do_re/do_im/do_vld    output sample stream, do_sos marks first CP sample
//     err                   sticky: symbol restarted before it was complete
// ---------------------------------------------------------------------------
module ofdm_cp_insert
   import ofdm_cp_insert_pkg::*;
#(
   parameter int DW   = CPI_DW,
   parameter int NFFT = CPI_NFFT,
   parameter int NCP  = CPI_NCP
) (
   input  logic          pld_clk,
   input  logic          pld_rst,
   input  logic [DW-1:0] di_re,
   input  logic [DW-1:0] di_im,
   input  logic          di_vld,
   input  logic          di_sos,
   output logic          di_rdy,
   output logic [DW-1:0] do_re,
   output logic [DW-1:0] do_im,
   output logic          do_vld,
   output logic          do_sos,
   output logic          err
);

   localparam int            IW       = $clog2(NFFT);
   localparam int            AW       = IW + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NFFT - 1);
   localparam logic [IW-1:0] CP_LAST  = IW'(NCP - 1);
   localparam logic [IW-1:0] CP_BASE  = IW'(NFFT - NCP);

   logic [1:0]      r_full;
   logic            r_wr_bank;
   logic [IW-1:0]   r_wr_idx;
   logic            r_err;
   rd_state_t       r_state;
   logic            r_rd_bank;
   logic [IW-1:0]   r_rd_cnt;
   logic            r_v1;
   logic            r_sos1;

   logic            w_acc;
   logic            w_set_full;
   logic            w_rel;
   logic            w_rd_en;
   logic [IW-1:0]   w_rd_idx;
   logic [AW-1:0]   w_waddr;
   logic [AW-1:0]   w_raddr;
   logic [2*DW-1:0] w_rdata;

`ifdef CPI_WIN_EN
   logic            r_bb;     // current symbol follows the previous one directly
   logic            r_win1;   // RAM output is a sample to be windowed

   // Floor of the mean of two signed samples: DW+1 bit sum, arithmetic >>1
   function automatic logic [DW-1:0] win_avg(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      logic [DW:0] sum;
      sum = {a[DW-1], a} + {b[DW-1], b};
      return sum[DW:1];
   endfunction
`endif

   assign di_rdy     = ~r_full[r_wr_bank];
   assign err        = r_err;
   assign w_acc      = di_vld & di_rdy;
   // A restart (di_sos) never completes a symbol, even at the last index
   assign w_set_full = w_acc & ~di_sos & (r_wr_idx == LAST_IDX);
   assign w_rel      = (r_state == ST_BODY) && (r_rd_cnt == LAST_IDX);
   assign w_rd_en    = (r_state == ST_CP) || (r_state == ST_BODY);
   assign w_waddr    = {r_wr_bank, (di_sos ? {IW{1'b0}} : r_wr_idx)};
   assign w_raddr    = {r_rd_bank, w_rd_idx};

   // Read index: prefix replays the symbol tail, body starts at 0
   always_comb begin
      w_rd_idx = r_rd_cnt;
      if (r_state == ST_CP) begin
         w_rd_idx = CP_BASE + r_rd_cnt;
      end else begin
         w_rd_idx = r_rd_cnt;
      end
   end

   cpi_dpram #(
      .AW (AW),
      .WW (2*DW)
   ) u_ram (
      .i_clk   (pld_clk),
      .i_we    (w_acc),
      .i_waddr (w_waddr),
      .i_wdata ({di_re, di_im}),
      .i_re    (w_rd_en),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Write index, write bank toggle and sticky restart error
   always_ff @(posedge pld_clk or posedge pld_rst) begin
      if (pld_rst) begin
         r_wr_bank <= 1'b0;
         r_wr_idx  <= {IW{1'b0}};
         r_err     <= 1'b0;
      end else if (w_acc) begin
         if (di_sos) begin
            if (r_wr_idx != {IW{1'b0}}) begin
               r_err <= 1'b1;
            end
            r_wr_idx <= IW'(1);
         end else if (r_wr_idx == LAST_IDX) begin
            r_wr_bank <= ~r_wr_bank;
            r_wr_idx  <= {IW{1'b0}};
         end else begin
            r_wr_idx <= r_wr_idx + IW'(1);
         end
      end
   end

   // Bank full flags: set and release always target different banks
   always_ff @(posedge pld_clk or posedge pld_rst) begin
      if (pld_rst) begin
         r_full <= 2'b00;
      end else begin
         if (w_set_full) begin
            r_full[r_wr_bank] <= 1'b1;
         end
         if (w_rel) begin
            r_full[r_rd_bank] <= 1'b0;
         end
      end
   end

   // Read FSM plus the RAM-stage valid/sos pipeline
   always_ff @(posedge pld_clk or posedge pld_rst) begin
      if (pld_rst) begin
         r_state   <= ST_IDLE;
         r_rd_bank <= 1'b0;
         r_rd_cnt  <= {IW{1'b0}};
         r_v1      <= 1'b0;
         r_sos1    <= 1'b0;
`ifdef CPI_WIN_EN
         r_bb      <= 1'b0;
         r_win1    <= 1'b0;
`endif
      end else begin
         r_v1   <= w_rd_en;
         r_sos1 <= (r_state == ST_CP) && (r_rd_cnt == {IW{1'b0}});
`ifdef CPI_WIN_EN
         r_win1 <= (r_state == ST_CP) && (r_rd_cnt == {IW{1'b0}}) && r_bb;
`endif
         case (r_state)
            ST_IDLE: begin
               if (r_full[r_rd_bank]) begin
                  r_state  <= ST_CP;
                  r_rd_cnt <= {IW{1'b0}};
`ifdef CPI_WIN_EN
                  r_bb     <= 1'b0;
`endif
               end
            end
            ST_CP: begin
               if (r_rd_cnt == CP_LAST) begin
                  r_state  <= ST_BODY;
                  r_rd_cnt <= {IW{1'b0}};
               end else begin
                  r_rd_cnt <= r_rd_cnt + IW'(1);
               end
            end
            ST_BODY: begin
               if (r_rd_cnt == LAST_IDX) begin
                  r_rd_bank <= ~r_rd_bank;
                  r_rd_cnt  <= {IW{1'b0}};
                  // Chain straight into the next prefix if it is waiting
                  if (r_full[~r_rd_bank]) begin
                     r_state <= ST_CP;
`ifdef CPI_WIN_EN
                     r_bb    <= 1'b1;
`endif
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_rd_cnt <= r_rd_cnt + IW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output register; while windowing, do_re/do_im still hold the
   // previous symbol's last sample, emitted on the preceding cycle
   always_ff @(posedge pld_clk or posedge pld_rst) begin
      if (pld_rst) begin
         do_re  <= {DW{1'b0}};
         do_im  <= {DW{1'b0}};
         do_vld <= 1'b0;
         do_sos <= 1'b0;
      end else begin
         do_vld <= r_v1;
         do_sos <= r_sos1;
         if (r_v1) begin
`ifdef CPI_WIN_EN
            if (r_win1) begin
               do_re <= win_avg(w_rdata[2*DW-1:DW], do_re);
               do_im <= win_avg(w_rdata[DW-1:0], do_im);
            end else begin
               do_re <= w_rdata[2*DW-1:DW];
               do_im <= w_rdata[DW-1:0];
            end
`else
            do_re <= w_rdata[2*DW-1:DW];
            do_im <= w_rdata[DW-1:0];
`endif
         end
      end
   end

endmodule
